// File: rtl/clock_pkg.sv
// Shared mode encodings for the HH:MM clock controller and its counter datapath.
package clock_pkg;

  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SET_HOUR   = 2'b01,
    SET_MINUTE = 2'b10
  } clk_mode_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus tick-based stability counter for one raw button.
module btn_debounce #(
  parameter int unsigned DB_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any agreeing cycle restarts the count, so only consecutive disagreeing ticks accumulate.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DB_TICKS - 1)) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Mode FSM and adjust-strobe generator (auto-repeat, timeout, blink) for the HH:MM counter.
module clock_adjust_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DB_TICKS      = 20,
  parameter int unsigned HOLD_TICKS    = 500,
  parameter int unsigned REPEAT_TICKS  = 100,
  parameter int unsigned TIMEOUT_TICKS = 10000,
  parameter int unsigned BLINK_TICKS   = 250
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tick,
  input  logic  set,
  input  logic  inc,
  input  logic  cen,
  output mode_t mode,
  output logic  run_en,
  output logic  hour_up,
  output logic  hour_dn,
  output logic  min_up,
  output logic  min_dn,
  output logic  sec_clear,
  output logic  blank_hour,
  output logic  blank_min
);

  localparam int unsigned TMAX = max_u(max_u(max_u(HOLD_TICKS, REPEAT_TICKS),
                                             max_u(TIMEOUT_TICKS, BLINK_TICKS)), DB_TICKS);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic set_level_unused;
  logic set_rise;
  logic inc_lvl;
  logic inc_rise;
  logic cen_lvl;
  logic cen_rise_unused;

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (set),
    .level (set_level_unused),
    .rise  (set_rise)
  );

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_inc (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (inc),
    .level (inc_lvl),
    .rise  (inc_rise)
  );

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_cen (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (cen),
    .level (cen_lvl),
    .rise  (cen_rise_unused)
  );

  clk_mode_e         state_q;
  clk_mode_e         state_d;
  logic              sec_clr_d;
  logic              in_set;
  logic              stay;
  logic              to_hit;
  logic              rep_due;
  logic              fire;

  logic [TW-1:0]     to_cnt;
  logic [TW-1:0]     rep_cnt;
  logic              rep_armed;
  logic              rep_hold;
  logic [TW-1:0]     blk_cnt;
  logic              blk_ph;

  always_comb begin
    state_d   = state_q;
    sec_clr_d = 1'b0;
    in_set    = (state_q == SET_HOUR) || (state_q == SET_MINUTE);
    to_hit    = in_set && tick && (to_cnt == TW'(TIMEOUT_TICKS - 1));

    case (state_q)
      IDLE: begin
        if (set_rise) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (set_rise)    state_d = SET_MINUTE;
        else if (to_hit) state_d = IDLE;
      end
      SET_MINUTE: begin
        if (set_rise) begin
          state_d   = IDLE;
          sec_clr_d = 1'b1;
        end else if (to_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A set press (or timeout) in the same cycle suppresses any adjust strobe.
    stay    = in_set && (state_d == state_q);
    rep_due = rep_armed && inc_lvl && tick &&
              (rep_hold ? (rep_cnt == TW'(HOLD_TICKS - 1))
                        : (rep_cnt == TW'(REPEAT_TICKS - 1)));
    fire    = stay && (inc_rise || rep_due);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hour_up   <= 1'b0;
      hour_dn   <= 1'b0;
      min_up    <= 1'b0;
      min_dn    <= 1'b0;
      sec_clear <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_up   <= fire && (state_q == SET_HOUR)   && !cen_lvl;
      hour_dn   <= fire && (state_q == SET_HOUR)   &&  cen_lvl;
      min_up    <= fire && (state_q == SET_MINUTE) && !cen_lvl;
      min_dn    <= fire && (state_q == SET_MINUTE) &&  cen_lvl;
      sec_clear <= sec_clr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_armed <= 1'b0;
      rep_hold  <= 1'b0;
      rep_cnt   <= '0;
    end else if (!stay || !inc_lvl) begin
      rep_armed <= 1'b0;
      rep_hold  <= 1'b0;
      rep_cnt   <= '0;
    end else if (inc_rise) begin
      rep_armed <= 1'b1;
      rep_hold  <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_due) begin
      rep_hold  <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_armed && tick) begin
      rep_cnt   <= rep_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (!in_set || (state_d != state_q) || set_rise || inc_rise || inc_lvl) begin
      to_cnt <= '0;
    end else if (tick) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt <= '0;
      blk_ph  <= 1'b0;
    end else if (!in_set || (state_d != state_q) || inc_lvl || fire) begin
      blk_cnt <= '0;
      blk_ph  <= 1'b0;
    end else if (tick) begin
      if (blk_cnt == TW'(BLINK_TICKS - 1)) begin
        blk_cnt <= '0;
        blk_ph  <= ~blk_ph;
      end else begin
        blk_cnt <= blk_cnt + TW'(1);
      end
    end
  end

  assign mode       = state_q;
  assign run_en     = (state_q == IDLE);
  assign blank_hour = blk_ph && (state_q == SET_HOUR)   && !inc_lvl;
  assign blank_min  = blk_ph && (state_q == SET_MINUTE) && !inc_lvl;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Self-checking bench for clock_adjust_ctrl: strobe scoreboard plus direct mode/blink checks.
module tb_clock_adjust_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b1;
  logic       set = 1'b0;
  logic       inc = 1'b0;
  logic       cen = 1'b0;
  logic [1:0] mode;
  logic       run_en, hour_up, hour_dn, min_up, min_dn, sec_clear, blank_hour, blank_min;
  logic [3:0] strb_w;

  int cyc = 0;
  int n_checks = 0;
  int n_errs = 0;

  typedef struct { int cyc; logic [3:0] strb; } sb_t;
  typedef struct { int unsigned presses; logic cen; logic [3:0] exp; } vec_t;

  sb_t  exp_q[$];
  sb_t  obs_q[$];
  vec_t tbl[6];

  clock_adjust_ctrl #(
    .DB_TICKS      (2),
    .HOLD_TICKS    (5),
    .REPEAT_TICKS  (2),
    .TIMEOUT_TICKS (20),
    .BLINK_TICKS   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .set        (set),
    .inc        (inc),
    .cen        (cen),
    .mode       (mode),
    .run_en     (run_en),
    .hour_up    (hour_up),
    .hour_dn    (hour_dn),
    .min_up     (min_up),
    .min_dn     (min_dn),
    .sec_clear  (sec_clear),
    .blank_hour (blank_hour),
    .blank_min  (blank_min)
  );

  assign strb_w = {hour_up, hour_dn, min_up, min_dn};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic sb_compare();
    sb_t o;
    sb_t e;
    chk("sb_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk("sb_cyc", o.cyc, e.cyc);
      chk("sb_strobe", int'(o.strb), int'(e.strb));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; set = 1'b0; inc = 1'b0; cen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Press event lands 4 cycles after driving; new mode is visible one cycle later.
  task automatic press_set_chk(input int exp_mode, input int exp_clr);
    @(negedge clk);
    set = 1'b1;
    repeat (4) @(negedge clk);
    chk("sec_clear_pre", sec_clear, 0);
    @(negedge clk);
    chk("mode", mode, exp_mode);
    chk("run_en", run_en, (exp_mode == 0) ? 1 : 0);
    chk("sec_clear", sec_clear, exp_clr);
    @(negedge clk);
    chk("sec_clear_width", sec_clear, 0);
    set = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          if (strb_w != 4'b0000) obs_q.push_back('{cyc, strb_w});
        end
      end
      begin
        int d;
        tbl[0] = '{1, 1'b0, 4'b1000};
        tbl[1] = '{1, 1'b1, 4'b0100};
        tbl[2] = '{2, 1'b0, 4'b0010};
        tbl[3] = '{2, 1'b1, 4'b0001};
        tbl[4] = '{0, 1'b0, 4'b0000};
        tbl[5] = '{0, 1'b1, 4'b0000};

        // Reset values and mode cycle
        do_reset();
        chk("rst_mode", mode, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_strobes", strb_w, 0);
        chk("rst_sec_clear", sec_clear, 0);
        chk("rst_blank", {blank_hour, blank_min}, 0);
        press_set_chk(1, 0);
        press_set_chk(2, 0);
        press_set_chk(0, 1);
        sb_compare();

        // Single inc press per state and direction
        for (int i = 0; i < 6; i++) begin
          do_reset();
          for (int unsigned p = 0; p < tbl[i].presses; p++) press_set_chk(int'(p) + 1, 0);
          cen = tbl[i].cen;
          repeat (6) @(negedge clk);
          d = cyc;
          inc = 1'b1;
          if (tbl[i].exp != 4'b0000) exp_q.push_back('{d + 5, tbl[i].exp});
          repeat (4) @(negedge clk);
          inc = 1'b0;
          repeat (8) @(negedge clk);
          sb_compare();
          chk("tbl_mode", mode, int'(tbl[i].presses));
        end

        // Auto-repeat in SET_MINUTE
        do_reset();
        press_set_chk(1, 0);
        press_set_chk(2, 0);
        cen = 1'b0;
        repeat (6) @(negedge clk);
        d = cyc;
        inc = 1'b1;
        exp_q.push_back('{d + 5,  4'b0010});
        exp_q.push_back('{d + 10, 4'b0010});
        exp_q.push_back('{d + 12, 4'b0010});
        exp_q.push_back('{d + 14, 4'b0010});
        exp_q.push_back('{d + 16, 4'b0010});
        exp_q.push_back('{d + 18, 4'b0010});
        repeat (9) @(negedge clk);
        chk("blank_min_held", blank_min, 0);
        repeat (5) @(negedge clk);
        inc = 1'b0;
        repeat (14) @(negedge clk);
        sb_compare();
        chk("repeat_mode", mode, 2);

        // One-cycle inc glitch gives nothing
        do_reset();
        press_set_chk(1, 0);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        repeat (10) @(negedge clk);
        sb_compare();

        // set and inc debounce together: set wins, no strobe, no repeat armed
        do_reset();
        press_set_chk(1, 0);
        set = 1'b1;
        inc = 1'b1;
        repeat (5) @(negedge clk);
        chk("prec_mode", mode, 2);
        repeat (5) @(negedge clk);
        set = 1'b0;
        repeat (10) @(negedge clk);
        inc = 1'b0;
        repeat (8) @(negedge clk);
        sb_compare();

        // Timeout and blink in SET_HOUR
        do_reset();
        set = 1'b1;
        repeat (4) @(negedge clk);
        set = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 22; t++) begin
          chk("to_mode", mode, (t < 20) ? 1 : 0);
          chk("to_blank_hour", blank_hour, (t < 20) ? ((t / 3) % 2) : 0);
          chk("to_sec_clear", sec_clear, 0);
          @(negedge clk);
        end
        sb_compare();

        // Async reset during auto-repeat
        do_reset();
        press_set_chk(1, 0);
        cen = 1'b0;
        repeat (6) @(negedge clk);
        d = cyc;
        inc = 1'b1;
        exp_q.push_back('{d + 5,  4'b1000});
        exp_q.push_back('{d + 10, 4'b1000});
        exp_q.push_back('{d + 12, 4'b1000});
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_strobe", strb_w, 8);
        rst = 1'b0;
        #1;
        chk("arst_strobes", strb_w, 0);
        chk("arst_mode", mode, 0);
        chk("arst_run_en", run_en, 1);
        chk("arst_blank", {blank_hour, blank_min}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_mode", mode, 0);
        chk("post_rst_run_en", run_en, 1);
        inc = 1'b0;
        repeat (6) @(negedge clk);
        sb_compare();
      end
    join_any
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_adjust_ctrl.md
Name: clock_adjust_ctrl

Overview:
Front-end controller for the HH:MM counter datapath. It debounces the set, inc and cen user inputs and runs the IDLE/SET_HOUR/SET_MINUTE mode FSM. It issues single-cycle up/down adjust strobes with hold-to-auto-repeat, plus run-enable, seconds-clear and display-blink controls. The counter becomes a pure datapath driven by these strobes.

Parameters:
DB_TICKS, 20, consecutive stable ticks required to accept a button level change
HOLD_TICKS, 500, ticks inc must be held after press before auto-repeat starts
REPEAT_TICKS, 100, ticks between auto-repeat strobes
TIMEOUT_TICKS, 10000, ticks without a press event in a SET state before forced return to IDLE
BLINK_TICKS, 250, ticks per blink half-period of the field being edited

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
tick  in  1  one-cycle timebase strobe (nominally 1 kHz); all timers advance only on tick
set  in  1  raw mode button
inc  in  1  raw adjust button
cen  in  1  raw direction: 0 = up, 1 = down
mode  out  2  current FSM state
run_en  out  1  1 = datapath free-runs (state IDLE)
hour_up  out  1  one-cycle strobe: increment hours
hour_dn  out  1  one-cycle strobe: decrement hours
min_up  out  1  one-cycle strobe: increment minutes
min_dn  out  1  one-cycle strobe: decrement minutes
sec_clear  out  1  one-cycle strobe: zero the seconds counter
blank_hour  out  1  1 = blank hour digits
blank_min  out  1  1 = blank minute digits

Behaviour:
- Reset (rst=0, async): mode=IDLE, run_en=1, all strobes=0, blank_*=0, debounced levels=0, all timers=0.
- Input path: 2-FF synchronizer on set, inc and cen.
- Debounce: a debounced level adopts the synced raw level after DB_TICKS consecutive ticks that disagree with the current debounced level. A disagreement that ends early resets that input's count.
- A press event is a 0->1 edge of the debounced level, one cycle wide.
- A button held through reset release produces a press once debounce completes.
- cen is debounced but generates no events; its debounced level is sampled at each adjust strobe.
- FSM encoding: IDLE=2'b00, SET_HOUR=2'b01, SET_MINUTE=2'b10. 2'b11 is unreachable; if entered, go to IDLE next cycle.
- set press transitions: IDLE->SET_HOUR, SET_HOUR->SET_MINUTE, SET_MINUTE->IDLE.
- sec_clear pulses in the same cycle the state changes SET_MINUTE->IDLE.
- The mode output registers the state; state change is visible the cycle after the press event.
- inc press in SET_HOUR/SET_MINUTE produces one strobe on the cycle after the event: hour_* or min_* per state, _up if cen=0, _dn if cen=1.
- inc press in IDLE is ignored.
- Auto-repeat:
  - While inc stays debounced-high, after HOLD_TICKS ticks issue a strobe, then one every REPEAT_TICKS ticks.
  - Debounced inc falling stops repeat immediately.
  - A state change cancels repeat; the new state needs a fresh press.
- Set press and inc press in the same cycle: set wins; the inc event is discarded and repeat is not armed.
- At most one strobe is asserted in any cycle.
- Timeout:
  - The timer clears on entering a SET state and on every press event; it also holds at 0 while inc is held.
  - Reaching TIMEOUT_TICKS returns the FSM to IDLE without a sec_clear.
- Blink:
  - On entering SET_HOUR, blank_hour=0 and toggles every BLINK_TICKS ticks.
  - Forced 0 while debounced inc is high and on each adjust strobe (phase restarts).
  - blank_min behaves the same in SET_MINUTE.
  - Both are 0 in IDLE.
- run_en = (state==IDLE), registered with state.
- Timers are saturating-free up-counters of width $clog2(max param + 1).
- A tick in the same cycle as a counter clear: the clear wins.
- Reset mid-operation aborts everything to reset values; no strobe is emitted on reset assertion.

Decomposition:
- Shared package clock_pkg: state encodings IDLE/SET_HOUR/SET_MINUTE, and a typedef for the 2-bit mode. The counter datapath and this block both import it.
- One sub-module, btn_debounce (2-FF sync + tick-based stability counter, parameter DB_TICKS; outputs level and rise pulse), instantiated three times.

Test Plan:
For all scenarios: tick=1 every cycle, DB_TICKS=2, HOLD_TICKS=5, REPEAT_TICKS=2, TIMEOUT_TICKS=20, BLINK_TICKS=3.
1. Mode cycle: three clean set presses -> mode goes 01, 10, 00; run_en=0 in SET states; sec_clear is high exactly one cycle on the 10->00 transition.
2. Adjust direction: in SET_HOUR, cen=0 then inc pulse -> exactly one hour_up; cen=1 then inc pulse -> exactly one hour_dn; min_* stay 0 throughout.
3. Auto-repeat: in SET_MINUTE, cen=0, hold inc 14 ticks after debounce -> min_up at press+1, then at +5, +7, +9, +11, +13 ticks; none after release.
4. Bounce and precedence:
   - inc glitch of 1 tick -> no strobe.
   - set and inc debounced on the same cycle in SET_HOUR -> mode becomes 10, no strobe.
5. Timeout and blink: enter SET_HOUR, idle 20 ticks -> mode returns to 00, no sec_clear; blank_hour toggles at ticks 3, 6, 9, ... before the timeout.
6. Reset mid-repeat: drive rst=0 during auto-repeat -> all outputs at reset values asynchronously, mode=00, run_en=1; holding inc through release gives no strobe (state is IDLE).
